// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline.
// Bundles decoded control into ctrl_t and provides capture sanitising.
package mips_pipe_pkg;

  localparam int DW  = 32;
  localparam int RAW = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_SLLV = 4'b1001;
  localparam logic [3:0] ALU_ASR  = 4'b1010;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       rfwe;
    logic       rfdsel;
    logic       alu_in_sel;
    logic       branch;
    logic       dmwe;
    logic       mtorfsel;
    logic [3:0] alu_op_sel;
  } ctrl_t;

  // Decode leaves don't-care fields undriven; force them to 0.
  function automatic ctrl_t ctrl_sanitize(
    input ctrl_t c,
    input logic  jump
  );
    ctrl_t r;
    r = '0;
    if (jump !== 1'b1) begin
      r.rfwe       = c.rfwe === 1'b1;
      r.rfdsel     = r.rfwe & (c.rfdsel === 1'b1);
      r.mtorfsel   = r.rfwe & (c.mtorfsel === 1'b1);
      r.alu_in_sel = c.alu_in_sel === 1'b1;
      r.branch     = c.branch === 1'b1;
      r.dmwe       = c.dmwe === 1'b1;
      for (int i = 0; i < 4; i++)
        r.alu_op_sel[i] = c.alu_op_sel[i] === 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between EX and decode.
// Shared with the forwarding unit.
module load_use_detect
  import mips_pipe_pkg::*;
#(
  parameter int RAW = mips_pipe_pkg::RAW
) (
  input  logic           valid_e,
  input  logic           rfwe_e,
  input  logic           mtorfsel_e,
  input  logic [RAW-1:0] rt_e,
  input  logic [RAW-1:0] rs_d,
  input  logic [RAW-1:0] rt_d,
  output logic           lu
);

  logic nz;
  logic hit;

  assign nz  = |rt_e;
  assign hit = (rt_e == rs_d) | (rt_e == rt_d);
  assign lu  = valid_e & rfwe_e & mtorfsel_e
             & nz & hit;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush.
// Optional ID_EX_PERF_CNT_EN adds bubble/flush counters.
module id_ex_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int DW  = mips_pipe_pkg::DW,
  parameter int RAW = mips_pipe_pkg::RAW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rfwe_d,
  input  logic           rfdsel_d,
  input  logic           alu_in_sel_d,
  input  logic           branch_d,
  input  logic           dmwe_d,
  input  logic           mtorfsel_d,
  input  logic           jump_d,
  input  logic [3:0]     alu_op_sel_d,
  input  logic [DW-1:0]  rd1_d,
  input  logic [DW-1:0]  rd2_d,
  input  logic [DW-1:0]  imm_d,
  input  logic [DW-1:0]  pc4_d,
  input  logic [RAW-1:0] rs_d,
  input  logic [RAW-1:0] rt_d,
  input  logic [RAW-1:0] rd_d,
  input  logic           flush_e,
  output logic           rfwe_e,
  output logic           rfdsel_e,
  output logic           alu_in_sel_e,
  output logic           branch_e,
  output logic           dmwe_e,
  output logic           mtorfsel_e,
  output logic [3:0]     alu_op_sel_e,
  output logic [DW-1:0]  rd1_e,
  output logic [DW-1:0]  rd2_e,
  output logic [DW-1:0]  imm_e,
  output logic [DW-1:0]  pc4_e,
  output logic [RAW-1:0] rs_e,
  output logic [RAW-1:0] rt_e,
  output logic [RAW-1:0] rd_e,
  output logic           valid_e,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]    bubble_cnt,
  output logic [31:0]    flush_cnt,
`endif
  output logic           stall_f,
  output logic           stall_d
);

  ctrl_t          ctrl_q;
  ctrl_t          ctrl_d;
  ctrl_t          ctrl_raw;
  logic [DW-1:0]  rd1_q, rd2_q, imm_q, pc4_q;
  logic [RAW-1:0] rs_q, rt_q, rd_q;
  logic           valid_q;
  logic           lu;
  logic           bubble;

  load_use_detect #(.RAW(RAW)) u_lu (
    .valid_e    (valid_q),
    .rfwe_e     (ctrl_q.rfwe),
    .mtorfsel_e (ctrl_q.mtorfsel),
    .rt_e       (rt_q),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .lu         (lu)
  );

  assign ctrl_raw = '{
    rfwe:       rfwe_d,
    rfdsel:     rfdsel_d,
    alu_in_sel: alu_in_sel_d,
    branch:     branch_d,
    dmwe:       dmwe_d,
    mtorfsel:   mtorfsel_d,
    alu_op_sel: alu_op_sel_d
  };
  assign ctrl_d = ctrl_sanitize(ctrl_raw, jump_d);
  assign bubble = flush_e | lu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else if (bubble) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= 1'b1;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (flush_e && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + 32'd1;
      if (lu && !flush_e && !(&bubble_cnt_q))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

  assign stall_f      = lu & ~flush_e;
  assign stall_d      = lu & ~flush_e;
  assign rfwe_e       = ctrl_q.rfwe;
  assign rfdsel_e     = ctrl_q.rfdsel;
  assign alu_in_sel_e = ctrl_q.alu_in_sel;
  assign branch_e     = ctrl_q.branch;
  assign dmwe_e       = ctrl_q.dmwe;
  assign mtorfsel_e   = ctrl_q.mtorfsel;
  assign alu_op_sel_e = ctrl_q.alu_op_sel;
  assign rd1_e        = rd1_q;
  assign rd2_e        = rd2_q;
  assign imm_e        = imm_q;
  assign pc4_e        = pc4_q;
  assign rs_e         = rs_q;
  assign rt_e         = rt_q;
  assign rd_e         = rd_q;
  assign valid_e      = valid_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed self-checking bench for id_ex_pipe_stage.
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
module tb_id_ex_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rfwe_d, rfdsel_d, alu_in_sel_d, branch_d;
  logic        dmwe_d, mtorfsel_d, jump_d;
  logic [3:0]  alu_op_sel_d;
  logic [31:0] rd1_d, rd2_d, imm_d, pc4_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic        flush_e;
  logic        rfwe_e, rfdsel_e, alu_in_sel_e, branch_e;
  logic        dmwe_e, mtorfsel_e;
  logic [3:0]  alu_op_sel_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc4_e;
  logic [4:0]  rs_e, rt_e, rd_e;
  logic        valid_e, stall_f, stall_d;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_pipe_stage dut (
    .clk(clk), .rst_n(rst_n),
    .rfwe_d(rfwe_d), .rfdsel_d(rfdsel_d),
    .alu_in_sel_d(alu_in_sel_d), .branch_d(branch_d),
    .dmwe_d(dmwe_d), .mtorfsel_d(mtorfsel_d),
    .jump_d(jump_d), .alu_op_sel_d(alu_op_sel_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .pc4_d(pc4_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .flush_e(flush_e),
    .rfwe_e(rfwe_e), .rfdsel_e(rfdsel_e),
    .alu_in_sel_e(alu_in_sel_e), .branch_e(branch_e),
    .dmwe_e(dmwe_e), .mtorfsel_e(mtorfsel_e),
    .alu_op_sel_e(alu_op_sel_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .pc4_e(pc4_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
    .valid_e(valid_e),
`ifdef ID_EX_PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
    .stall_f(stall_f), .stall_d(stall_d)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(
    input logic        we, dsel, ais, br, dmw, m2r, jmp,
    input logic [3:0]  op,
    input logic [4:0]  rs, rt, rd,
    input logic [31:0] a, b, im, pc
  );
    rfwe_d = we; rfdsel_d = dsel; alu_in_sel_d = ais;
    branch_d = br; dmwe_d = dmw; mtorfsel_d = m2r;
    jump_d = jmp; alu_op_sel_d = op;
    rs_d = rs; rt_d = rt; rd_d = rd;
    rd1_d = a; rd2_d = b; imm_d = im; pc4_d = pc;
  endtask

  task automatic set_nop;
    set_in(0,0,0,0,0,0,0, 4'd0, 5'd0,5'd0,5'd0, 0,0,0,0);
  endtask

  // lw $rt, imm($rs)
  task automatic set_lw(input logic [4:0] rs, rt);
    set_in(1,0,1,0,0,1,0, 4'b0010, rs,rt,5'd0,
           32'h10,0,32'h4,32'h200);
  endtask

  // add $rd, $rs, $rt
  task automatic set_add(input logic [4:0] rs, rt, rd);
    set_in(1,1,0,0,0,0,0, 4'b0010, rs,rt,rd,
           32'd5,32'd7,0,32'h104);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush_e = 1'b0; set_nop();
    #1;
    total++; if ({valid_e,rfwe_e,rd1_e,rt_e} !== '0) $display("FAIL rst_init got %h exp 0", {valid_e,rfwe_e,rd1_e,rt_e}); else passed++;
    total++; if (stall_f !== 1'b0) $display("FAIL rst_stall got %b exp 0", stall_f); else passed++;
    #2 rst_n = 1'b1;
    set_add(5'd1, 5'd2, 5'd3);
    tick();
    total++; if (valid_e !== 1'b1) $display("FAIL rst_traffic_valid got %b exp 1", valid_e); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({valid_e,rfwe_e,rfdsel_e,alu_op_sel_e,rd1_e,rd_e} !== '0) $display("FAIL rst_async got %h exp 0", {valid_e,rfwe_e,rfdsel_e,alu_op_sel_e,rd1_e,rd_e}); else passed++;
    #1 rst_n = 1'b1;
    set_lw(5'd9, 5'd8);
    tick();
    set_add(5'd8, 5'd2, 5'd3);
    #1;
    total++; if (stall_f !== 1'b1) $display("FAIL rst_prestall got %b exp 1", stall_f); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({stall_f,stall_d} !== 2'b00) $display("FAIL rst_midstall got %b exp 00", {stall_f,stall_d}); else passed++;
    set_nop();
    #1 rst_n = 1'b1;
  endtask

  task automatic test_pass_through;
    set_add(5'd1, 5'd2, 5'd3);
    tick();
    total++; if (rd1_e !== 32'd5 || rd2_e !== 32'd7) $display("FAIL pass_data got %0d/%0d exp 5/7", rd1_e, rd2_e); else passed++;
    total++; if (rd_e !== 5'd3 || rs_e !== 5'd1 || rt_e !== 5'd2) $display("FAIL pass_regs got %0d/%0d/%0d exp 1/2/3", rs_e, rt_e, rd_e); else passed++;
    total++; if ({rfwe_e,rfdsel_e,alu_in_sel_e,branch_e,dmwe_e,mtorfsel_e} !== 6'b110000) $display("FAIL pass_ctrl got %b exp 110000", {rfwe_e,rfdsel_e,alu_in_sel_e,branch_e,dmwe_e,mtorfsel_e}); else passed++;
    total++; if (alu_op_sel_e !== 4'b0010 || pc4_e !== 32'h104) $display("FAIL pass_op got %b/%h exp 0010/104", alu_op_sel_e, pc4_e); else passed++;
    total++; if (valid_e !== 1'b1 || stall_f !== 1'b0) $display("FAIL pass_valid got %b%b exp 10", valid_e, stall_f); else passed++;
  endtask

  task automatic test_load_use;
    set_lw(5'd9, 5'd8);
    tick();
    total++; if (mtorfsel_e !== 1'b1 || rt_e !== 5'd8) $display("FAIL lu_lw_cap got %b/%0d exp 1/8", mtorfsel_e, rt_e); else passed++;
    set_add(5'd8, 5'd10, 5'd11);
    #1;
    total++; if ({stall_f,stall_d} !== 2'b11) $display("FAIL lu_stall got %b exp 11", {stall_f,stall_d}); else passed++;
    tick();
    total++; if ({valid_e,rfwe_e,rs_e,rd1_e} !== '0) $display("FAIL lu_bubble got %h exp 0", {valid_e,rfwe_e,rs_e,rd1_e}); else passed++;
    total++; if (stall_f !== 1'b0) $display("FAIL lu_stall_clr got %b exp 0", stall_f); else passed++;
    tick();
    total++; if (valid_e !== 1'b1 || rs_e !== 5'd8 || rd_e !== 5'd11) $display("FAIL lu_replay got %b/%0d/%0d exp 1/8/11", valid_e, rs_e, rd_e); else passed++;
  endtask

  task automatic test_no_hazard;
    set_lw(5'd9, 5'd0);
    tick();
    set_add(5'd0, 5'd0, 5'd4);
    #1;
    total++; if (stall_f !== 1'b0) $display("FAIL nh_r0 got %b exp 0", stall_f); else passed++;
    set_in(1,0,1,0,0,0,0, 4'b0010, 5'd1,5'd8,5'd0, 0,0,32'd3,32'h300);
    tick();
    set_add(5'd8, 5'd2, 5'd4);
    #1;
    total++; if (stall_d !== 1'b0) $display("FAIL nh_addi got %b exp 0", stall_d); else passed++;
    set_lw(5'd9, 5'd8);
    tick();
    set_add(5'd3, 5'd8, 5'd4);
    #1;
    total++; if (stall_d !== 1'b1) $display("FAIL nh_rt_match got %b exp 1", stall_d); else passed++;
    tick();
    set_nop();
    tick();
  endtask

  task automatic test_flush;
    set_lw(5'd9, 5'd8);
    tick();
    set_add(5'd8, 5'd10, 5'd11);
    flush_e = 1'b1;
    #1;
    total++; if ({stall_f,stall_d} !== 2'b00) $display("FAIL fl_stall got %b exp 00", {stall_f,stall_d}); else passed++;
    tick();
    total++; if ({valid_e,rfwe_e,mtorfsel_e,rt_e,rd1_e} !== '0) $display("FAIL fl_bubble got %h exp 0", {valid_e,rfwe_e,mtorfsel_e,rt_e,rd1_e}); else passed++;
    flush_e = 1'b0;
    set_in(1,1,0,0,0,0,0, 4'b0011, 5'd1,5'd2,5'd4, 32'd9,32'd3,0,32'h108);
    tick();
    total++; if (valid_e !== 1'b1 || alu_op_sel_e !== 4'b0011 || rd_e !== 5'd4) $display("FAIL fl_next got %b/%b/%0d exp 1/0011/4", valid_e, alu_op_sel_e, rd_e); else passed++;
    set_add(5'd1, 5'd2, 5'd3);
    flush_e = 1'b1;
    tick();
    total++; if (valid_e !== 1'b0 || rd1_e !== 32'd0) $display("FAIL fl_plain got %b/%0d exp 0/0", valid_e, rd1_e); else passed++;
    flush_e = 1'b0;
  endtask

  task automatic test_sanitize;
    set_in(1'bx,1'bx,1'bx,1'bx,1'bx,1'bx,1'b1, 4'bxxxx,
           5'd0,5'd0,5'd0, 32'h55,0,32'h40,32'h10c);
    tick();
    total++; if ({rfwe_e,rfdsel_e,alu_in_sel_e,branch_e,dmwe_e,mtorfsel_e} !== 6'b0) $display("FAIL san_j_ctrl got %b exp 000000", {rfwe_e,rfdsel_e,alu_in_sel_e,branch_e,dmwe_e,mtorfsel_e}); else passed++;
    total++; if (alu_op_sel_e !== 4'b0000 || valid_e !== 1'b1) $display("FAIL san_j_op got %b/%b exp 0000/1", alu_op_sel_e, valid_e); else passed++;
    total++; if (rd1_e !== 32'h55 || pc4_e !== 32'h10c) $display("FAIL san_j_data got %h/%h exp 55/10c", rd1_e, pc4_e); else passed++;
    set_in(1'b0,1'bx,1'b1,1'b0,1'b1,1'bx,1'b0, 4'b0010,
           5'd2,5'd6,5'd0, 32'h20,32'h77,32'h8,32'h110);
    tick();
    total++; if ({rfwe_e,rfdsel_e,mtorfsel_e} !== 3'b000) $display("FAIL san_sw_wb got %b exp 000", {rfwe_e,rfdsel_e,mtorfsel_e}); else passed++;
    total++; if ({dmwe_e,alu_in_sel_e,alu_op_sel_e} !== 6'b110010) $display("FAIL san_sw_ctrl got %b exp 110010", {dmwe_e,alu_in_sel_e,alu_op_sel_e}); else passed++;
  endtask

  task automatic test_back_to_back;
    int bubbles;
    bubbles = 0;
    set_lw(5'd9, 5'd8);
    tick();
    set_lw(5'd8, 5'd9);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (!valid_e) bubbles++;
    end
    total++; if (rt_e !== 5'd9 || mtorfsel_e !== 1'b1) $display("FAIL b2b_lw2 got %0d/%b exp 9/1", rt_e, mtorfsel_e); else passed++;
    set_add(5'd9, 5'd1, 5'd12);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (!valid_e) bubbles++;
    end
    total++; if (rd_e !== 5'd12 || valid_e !== 1'b1) $display("FAIL b2b_add got %0d/%b exp 12/1", rd_e, valid_e); else passed++;
    total++; if (bubbles !== 2) $display("FAIL b2b_bubbles got %0d exp 2", bubbles); else passed++;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_sanitize();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
